// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_core_pkg
// Description : Shared constants and the fetch FSM state encoding for the
//               RV core front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_core_pkg;

    // Register / instruction width of the core
    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // Canonical NOP (addi x0,x0,0) and reset fetch address
    localparam logic [ILEN-1:0] RV_NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RV_RESET_PC  = 32'h0000_0000;

    // Fetch FSM state encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_BOOT  = 2'd0;
    localparam fetch_state_t ST_RUN   = 2'd1;
    localparam fetch_state_t ST_FAULT = 2'd2;

endpackage : rv_core_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID output stage. Holds one instruction and its PC under a
//               valid/ready handshake; supports flush and NOP fill when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_capture,
    input  logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;

    // Flush beats capture beats drain; with none of them the stage holds.
    // out_pc is left untouched on flush/drain since it is only meaningful
    // while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Owns the PC and fetch FSM, drives the
//               combinational-read instruction memory, handles redirects and
//               fetch faults, and counts instructions accepted by decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import rv_core_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_SIZE   = 512,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RV_RESET_PC,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = RV_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  fetch_fault,
    output logic [31:0]           fetch_count
);

    localparam logic [ADDR_WIDTH-3:0] c_mem_words = (ADDR_WIDTH-2)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step   = ADDR_WIDTH'(4);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  r_fault;
    logic [31:0]           r_count;
    logic                  w_pc_ok;
    logic                  w_capture;
    logic                  w_flush;
    logic                  w_out_valid;

    assign instr_addr = r_pc;
    assign w_pc_ok    = (r_pc[1:0] == 2'b00) && (r_pc[ADDR_WIDTH-1:2] < c_mem_words);

    // Next-state / next-PC decision. Redirect has priority; entering FAULT
    // also flushes so the stage is empty once the FSM is terminal, while a
    // handshake in the detection cycle still completes.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_BOOT, ST_RUN: begin
                if (r_state == ST_BOOT) begin
                    w_state_nxt = ST_RUN;
                end
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pc_nxt = redirect_pc;
                    end
                end else if (r_state == ST_RUN) begin
                    if (!w_pc_ok) begin
                        w_state_nxt = ST_FAULT;
                        w_flush     = 1'b1;
                    end else if (!w_out_valid || out_ready) begin
                        w_capture = 1'b1;
                        w_pc_nxt  = r_pc + c_pc_step;
                    end
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_FAULT;
                w_flush     = 1'b1;
            end
        endcase
    end

    // PC, FSM state and sticky fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_state_nxt == ST_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Retired-fetch counter: every decode handshake, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_out_valid && out_ready) begin
            r_count <= r_count + 32'd1;
        end
    end

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (w_flush),
        .i_capture (w_capture),
        .i_ready   (out_ready),
        .i_instr   (instr),
        .i_pc      (r_pc),
        .o_valid   (w_out_valid),
        .o_instr   (out_instr),
        .o_pc      (out_pc)
    );

    assign out_valid   = w_out_valid;
    assign fetch_fault = r_fault;
    assign fetch_count = r_count;

endmodule : instr_fetch
`default_nettype wire
